// File: rtl/pipe_stall_regs.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stall_regs
// Description : Front-end pipeline registers (PC, IF/ID, ID/EX, EX/MEM
//               hazard fields) with branch redirect, stall counter and
//               stall watchdog.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_stall_regs #(
    parameter int PC_W  = 16,
    parameter int IW    = 16,
    parameter int CW    = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             PC_Hold,
    input  logic             IF_ID_Hold,
    input  logic             ID_EX_Flush,
    input  logic             Branch_Taken,
    input  logic [PC_W-1:0]  Branch_Target,
    input  logic [IW-1:0]    IF_Instr,
    input  logic [2:0]       ID_RD,
    input  logic             ID_RegWrite,
    input  logic [CW-1:0]    ID_Ctrl,
    output logic [PC_W-1:0]  PC,
    output logic [IW-1:0]    IF_ID_Instr,
    output logic [PC_W-1:0]  IF_ID_PC1,
    output logic [2:0]       ID_EX_RD,
    output logic             ID_EX_RegWrite,
    output logic [CW-1:0]    ID_EX_Ctrl,
    output logic [2:0]       EX_MEM_RD,
    output logic             EX_MEM_RegWrite,
    output logic [CNT_W-1:0] Stall_Count,
    output logic             Stall_Error
);

    localparam logic [1:0] c_RUN_MAX   = 2'd3;
    localparam logic [1:0] c_RUN_LIMIT = 2'd2;

    logic [PC_W-1:0] w_pc_inc;
    logic            w_stall;
    logic [1:0]      r_run;

    assign w_pc_inc = PC + {{(PC_W-1){1'b0}}, 1'b1};
    // A taken branch overrides any hold, so that edge is never a stall.
    assign w_stall  = IF_ID_Hold & ~Branch_Taken;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            PC              <= '0;
            IF_ID_Instr     <= '0;
            IF_ID_PC1       <= '0;
            ID_EX_RD        <= '0;
            ID_EX_RegWrite  <= 1'b0;
            ID_EX_Ctrl      <= '0;
            EX_MEM_RD       <= '0;
            EX_MEM_RegWrite <= 1'b0;
            Stall_Count     <= '0;
            Stall_Error     <= 1'b0;
            r_run           <= '0;
        end else begin
            if (Branch_Taken) begin
                PC <= Branch_Target;
            end else if (!PC_Hold) begin
                PC <= w_pc_inc;
            end

            if (Branch_Taken) begin
                IF_ID_Instr <= '0;
                IF_ID_PC1   <= '0;
            end else if (!IF_ID_Hold) begin
                IF_ID_Instr <= IF_Instr;
                IF_ID_PC1   <= w_pc_inc;
            end

            if (Branch_Taken || ID_EX_Flush) begin
                ID_EX_RD       <= '0;
                ID_EX_RegWrite <= 1'b0;
                ID_EX_Ctrl     <= '0;
            end else begin
                ID_EX_RD       <= ID_RD;
                ID_EX_RegWrite <= ID_RegWrite;
                ID_EX_Ctrl     <= ID_Ctrl;
            end

            EX_MEM_RD       <= ID_EX_RD;
            EX_MEM_RegWrite <= ID_EX_RegWrite;

            if (w_stall) begin
                if (Stall_Count != '1) begin
                    Stall_Count <= Stall_Count + {{(CNT_W-1){1'b0}}, 1'b1};
                end
                if (r_run != c_RUN_MAX) begin
                    r_run <= r_run + 2'd1;
                end
                // A legitimate RAW stall never exceeds two consecutive cycles.
                if (r_run == c_RUN_LIMIT) begin
                    Stall_Error <= 1'b1;
                end
            end else begin
                r_run <= '0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pipe_stall_regs.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_stall_regs
// Description : Directed self-checking bench for pipe_stall_regs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_stall_regs;

    logic        clk;
    logic        rst;
    logic        PC_Hold;
    logic        IF_ID_Hold;
    logic        ID_EX_Flush;
    logic        Branch_Taken;
    logic [15:0] Branch_Target;
    logic [15:0] IF_Instr;
    logic [2:0]  ID_RD;
    logic        ID_RegWrite;
    logic [7:0]  ID_Ctrl;
    logic [15:0] PC;
    logic [15:0] IF_ID_Instr;
    logic [15:0] IF_ID_PC1;
    logic [2:0]  ID_EX_RD;
    logic        ID_EX_RegWrite;
    logic [7:0]  ID_EX_Ctrl;
    logic [2:0]  EX_MEM_RD;
    logic        EX_MEM_RegWrite;
    logic [15:0] Stall_Count;
    logic        Stall_Error;

    int n_tests;
    int n_failed;

    pipe_stall_regs #(
        .PC_W (16),
        .IW   (16),
        .CW   (8),
        .CNT_W(16)
    ) u_dut (
        .clk            (clk),
        .rst            (rst),
        .PC_Hold        (PC_Hold),
        .IF_ID_Hold     (IF_ID_Hold),
        .ID_EX_Flush    (ID_EX_Flush),
        .Branch_Taken   (Branch_Taken),
        .Branch_Target  (Branch_Target),
        .IF_Instr       (IF_Instr),
        .ID_RD          (ID_RD),
        .ID_RegWrite    (ID_RegWrite),
        .ID_Ctrl        (ID_Ctrl),
        .PC             (PC),
        .IF_ID_Instr    (IF_ID_Instr),
        .IF_ID_PC1      (IF_ID_PC1),
        .ID_EX_RD       (ID_EX_RD),
        .ID_EX_RegWrite (ID_EX_RegWrite),
        .ID_EX_Ctrl     (ID_EX_Ctrl),
        .EX_MEM_RD      (EX_MEM_RD),
        .EX_MEM_RegWrite(EX_MEM_RegWrite),
        .Stall_Count    (Stall_Count),
        .Stall_Error    (Stall_Error)
    );

    // Instruction memory returns 0x1000 + address.
    assign IF_Instr = 16'h1000 + PC;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".PC"},          32'(PC), 32'h0);
        check({tag, ".IF_ID_Instr"}, 32'(IF_ID_Instr), 32'h0);
        check({tag, ".IF_ID_PC1"},   32'(IF_ID_PC1), 32'h0);
        check({tag, ".ID_EX_RD"},    32'(ID_EX_RD), 32'h0);
        check({tag, ".ID_EX_RegW"},  32'(ID_EX_RegWrite), 32'h0);
        check({tag, ".ID_EX_Ctrl"},  32'(ID_EX_Ctrl), 32'h0);
        check({tag, ".EX_MEM_RD"},   32'(EX_MEM_RD), 32'h0);
        check({tag, ".EX_MEM_RegW"}, 32'(EX_MEM_RegWrite), 32'h0);
        check({tag, ".Stall_Count"}, 32'(Stall_Count), 32'h0);
        check({tag, ".Stall_Error"}, 32'(Stall_Error), 32'h0);
    endtask

    initial begin
        n_tests       = 0;
        n_failed      = 0;
        rst           = 1'b1;
        PC_Hold       = 1'b0;
        IF_ID_Hold    = 1'b0;
        ID_EX_Flush   = 1'b0;
        Branch_Taken  = 1'b0;
        Branch_Target = 16'h0;
        ID_RD         = 3'd0;
        ID_RegWrite   = 1'b0;
        ID_Ctrl       = 8'h00;

        #2;
        check_all_zero("reset");
        #1 rst = 1'b0;

        // Free-running fetch
        repeat (4) step();
        check("free.PC",          32'(PC), 32'd4);
        check("free.IF_ID_Instr", 32'(IF_ID_Instr), 32'h1003);
        check("free.IF_ID_PC1",   32'(IF_ID_PC1), 32'd4);
        check("free.Stall_Count", 32'(Stall_Count), 32'd0);

        // Producer r3 enters ID/EX
        ID_RD = 3'd3; ID_RegWrite = 1'b1; ID_Ctrl = 8'hA5;
        step();
        check("prod.PC",          32'(PC), 32'd5);
        check("prod.IF_ID_Instr", 32'(IF_ID_Instr), 32'h1004);
        check("prod.ID_EX_RD",    32'(ID_EX_RD), 32'd3);
        check("prod.ID_EX_RegW",  32'(ID_EX_RegWrite), 32'd1);
        check("prod.ID_EX_Ctrl",  32'(ID_EX_Ctrl), 32'hA5);

        // RAW stall: hold + flush for two edges
        ID_RD = 3'd4; ID_Ctrl = 8'h3C;
        PC_Hold = 1'b1; IF_ID_Hold = 1'b1; ID_EX_Flush = 1'b1;
        step();
        check("st1.PC",          32'(PC), 32'd5);
        check("st1.IF_ID_Instr", 32'(IF_ID_Instr), 32'h1004);
        check("st1.ID_EX_RD",    32'(ID_EX_RD), 32'd0);
        check("st1.ID_EX_RegW",  32'(ID_EX_RegWrite), 32'd0);
        check("st1.ID_EX_Ctrl",  32'(ID_EX_Ctrl), 32'h0);
        check("st1.EX_MEM_RD",   32'(EX_MEM_RD), 32'd3);
        check("st1.EX_MEM_RegW", 32'(EX_MEM_RegWrite), 32'd1);
        check("st1.Stall_Count", 32'(Stall_Count), 32'd1);
        step();
        check("st2.PC",          32'(PC), 32'd5);
        check("st2.IF_ID_PC1",   32'(IF_ID_PC1), 32'd5);
        check("st2.EX_MEM_RD",   32'(EX_MEM_RD), 32'd0);
        check("st2.EX_MEM_RegW", 32'(EX_MEM_RegWrite), 32'd0);
        check("st2.Stall_Count", 32'(Stall_Count), 32'd2);
        check("st2.Stall_Error", 32'(Stall_Error), 32'd0);

        PC_Hold = 1'b0; IF_ID_Hold = 1'b0; ID_EX_Flush = 1'b0;
        step();
        check("rel.PC",          32'(PC), 32'd6);
        check("rel.IF_ID_Instr", 32'(IF_ID_Instr), 32'h1005);
        check("rel.ID_EX_RD",    32'(ID_EX_RD), 32'd4);
        check("rel.ID_EX_Ctrl",  32'(ID_EX_Ctrl), 32'h3C);
        check("rel.Stall_Count", 32'(Stall_Count), 32'd2);

        // Watchdog: three consecutive stall edges
        PC_Hold = 1'b1; IF_ID_Hold = 1'b1;
        step(); step();
        check("wd2.Stall_Error", 32'(Stall_Error), 32'd0);
        step();
        check("wd3.Stall_Error", 32'(Stall_Error), 32'd1);
        check("wd3.Stall_Count", 32'(Stall_Count), 32'd5);
        PC_Hold = 1'b0; IF_ID_Hold = 1'b0;
        step();
        check("wdrel.Stall_Error", 32'(Stall_Error), 32'd1);
        check("wdrel.Stall_Count", 32'(Stall_Count), 32'd5);

        // Branch wins over holds, not counted as a stall
        Branch_Taken = 1'b1; Branch_Target = 16'h0040;
        PC_Hold = 1'b1; IF_ID_Hold = 1'b1;
        step();
        check("br.PC",          32'(PC), 32'h0040);
        check("br.IF_ID_Instr", 32'(IF_ID_Instr), 32'h0);
        check("br.IF_ID_PC1",   32'(IF_ID_PC1), 32'h0);
        check("br.ID_EX_RegW",  32'(ID_EX_RegWrite), 32'd0);
        check("br.Stall_Count", 32'(Stall_Count), 32'd5);
        Branch_Taken = 1'b0; PC_Hold = 1'b0; IF_ID_Hold = 1'b0;
        step();
        check("brtgt.IF_ID_Instr", 32'(IF_ID_Instr), 32'h1040);
        check("brtgt.PC",          32'(PC), 32'h0041);

        // PC wrap from all-ones
        Branch_Taken = 1'b1; Branch_Target = 16'hFFFF;
        step();
        check("wrap0.PC", 32'(PC), 32'hFFFF);
        Branch_Taken = 1'b0;
        step();
        check("wrap1.PC",          32'(PC), 32'h0000);
        check("wrap1.IF_ID_PC1",   32'(IF_ID_PC1), 32'h0000);
        check("wrap1.IF_ID_Instr", 32'(IF_ID_Instr), 32'h0FFF);

        // Async reset mid-stall; run must restart from zero afterwards
        IF_ID_Hold = 1'b1; PC_Hold = 1'b1;
        step(); step();
        #2 rst = 1'b1;
        #1;
        check_all_zero("arst");
        #1 rst = 1'b0;
        step();
        check("post.Stall_Count", 32'(Stall_Count), 32'd1);
        check("post.Stall_Error", 32'(Stall_Error), 32'd0);
        check("post.PC",          32'(PC), 32'd0);
        IF_ID_Hold = 1'b0; PC_Hold = 1'b0;
        step();
        check("post2.PC", 32'(PC), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipe_stall_regs.md
# pipe_stall_regs

Front-end pipeline register bank for the 5-stage, 8-register (3-bit address) pipeline. It consumes the hazard detector's `PC_Hold`, `IF_ID_Hold` and `ID_EX_Flush` requests and applies them to the PC, IF/ID and ID/EX registers. It also produces the `ID_EX_*` and `EX_MEM_*` destination/write-enable fields that feed back into the hazard detector. It adds the EX-stage branch redirect, a stall-cycle counter and a stall watchdog.

## Interface
- `PC_W`, default 16: PC width.
- `IW`, default 16: instruction width.
- `CW`, default 8: width of the ID-stage control bundle.
- `CNT_W`, default 16: stall counter width.
- `clk` in 1: the only clock. All state updates on the rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `PC_Hold` in 1: freeze PC.
- `IF_ID_Hold` in 1: freeze IF/ID.
- `ID_EX_Flush` in 1: load a bubble into ID/EX.
- `Branch_Taken` in 1: the EX stage resolved a taken branch.
- `Branch_Target` in `PC_W`: redirect address.
- `IF_Instr` in `IW`: instruction-memory data at `PC`.
- `ID_RD` in 3: destination register decoded in ID.
- `ID_RegWrite` in 1: register-write enable decoded in ID.
- `ID_Ctrl` in `CW`: remaining control bits decoded in ID.
- `PC` out `PC_W`: current fetch address.
- `IF_ID_Instr` out `IW`: instruction held in IF/ID.
- `IF_ID_PC1` out `PC_W`: PC+1 captured with that instruction.
- `ID_EX_RD` out 3: ID/EX destination register (to the hazard detector).
- `ID_EX_RegWrite` out 1: ID/EX write enable (to the hazard detector).
- `ID_EX_Ctrl` out `CW`: ID/EX control bundle.
- `EX_MEM_RD` out 3: EX/MEM destination register (to the hazard detector).
- `EX_MEM_RegWrite` out 1: EX/MEM write enable (to the hazard detector).
- `Stall_Count` out `CNT_W`: total stall cycles since reset, saturating.
- `Stall_Error` out 1: sticky watchdog flag.

## Operation
- Reset (async, immediate): all outputs are 0. `IF_ID_Instr` = 0 is the NOP encoding. The internal consecutive-stall counter `run` is cleared to 0.
- PC register, priority top-down:
  - `Branch_Taken`: `PC <= Branch_Target`.
  - else `PC_Hold`: `PC` unchanged.
  - else: `PC <= PC + 1`, modulo 2^`PC_W`, so `PC` wraps from all-ones to 0.
- IF/ID register:
  - `Branch_Taken`: load NOP; `IF_ID_PC1 <= 0`.
  - else `IF_ID_Hold`: unchanged.
  - else: `IF_ID_Instr <= IF_Instr` and `IF_ID_PC1 <= PC + 1`.
- ID/EX register:
  - `Branch_Taken` or `ID_EX_Flush`: bubble, i.e. `RD = 0`, `RegWrite = 0`, `Ctrl = 0`.
  - else: load `ID_RD`, `ID_RegWrite` and `ID_Ctrl`.
- EX/MEM fields: on every cycle, load the ID/EX values. No hold, no flush.
- A stall cycle is a rising edge with `IF_ID_Hold = 1` and `Branch_Taken = 0`.
- Stall accounting:
  - `Stall_Count` increments by 1 per stall cycle and saturates at all-ones.
  - `run` increments per stall cycle (saturating at 3) and clears on any non-stall edge.
- Watchdog:
  - The detector can legitimately stall for at most 2 consecutive cycles: the producer sits in ID/EX, then in EX/MEM.
  - When a stall cycle occurs with `run` already equal to 2, `Stall_Error` is set to 1.
  - `Stall_Error` stays at 1 until `rst`.
- Hold/flush signals that disagree are each applied independently as specified above, e.g. `IF_ID_Hold = 1` with `PC_Hold = 0`. No error is flagged for this.

## Timing
- Every output is registered. No combinational path from any input to any output.
- Hazard feedback loop:
  - A RAW hazard on the instruction in ID asserts hold+flush.
  - On the next edge the bubble enters ID/EX, and PC and IF/ID are frozen.
  - The producer moves from ID/EX to EX/MEM and then retires, so the loop self-terminates after at most 2 stall cycles.
- Branch redirect:
  - The edge with `Branch_Taken = 1` loads `Branch_Target` into `PC` and kills 2 younger instructions (IF/ID and ID/EX).
  - The instruction at the target appears in `IF_ID_Instr` one edge later.
- `Branch_Taken` together with any hold: the branch wins in every register, and the cycle is not counted as a stall.
- `rst` asserted mid-stall clears `run`, `Stall_Count` and `Stall_Error`. Deassertion is sampled by the next edge.

## Test plan
- Reset then 4 free-running edges with no holds, `IF_Instr` = 0x1000+PC → `PC` = 4, `IF_ID_Instr` = 0x1003, `IF_ID_PC1` = 4, `Stall_Count` = 0.
- ID_RD = 3 with RegWrite = 1, then hold+flush asserted for 2 cycles → `PC` and `IF_ID_Instr` frozen for 2 edges, two bubbles (`RD = 0`, `RegWrite = 0`) follow the producer into EX/MEM, `Stall_Count` = 2, `Stall_Error` = 0.
- Hold asserted for 3 consecutive edges → `Stall_Error` = 1 after the 3rd edge and stays at 1 after hold drops, until `rst`.
- `Branch_Taken` = 1, `Branch_Target` = 0x0040, with `PC_Hold` = `IF_ID_Hold` = 1 on the same edge → `PC` = 0x0040, `IF_ID_Instr` = 0, `ID_EX_RegWrite` = 0, `Stall_Count` unchanged.
- `PC` preset to 0xFFFF through a branch, then one free edge → `PC` = 0x0000.
- `rst` pulsed asynchronously between edges during a stall → all outputs 0 immediately, with no clock edge required.
